// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if -- bundle of every signal between the RAM controller, its host
// and the two 16x4 RAM chips.
//
// Host side : mar_load, addr_in, wr_req, rd_req, auto_inc, wdata (requests)
//             busy, rd_valid, rdata, mar (status / read data)
// RAM side  : ram_addr, ram_cs_n, ram_we_n, ram_d (to chips), ram_q (from chips)
//
// slave  : the controller (ram_ctrl)
// master : the environment (host plus RAM chips)
interface ram_ctrl_if;
  logic       mar_load;
  logic [3:0] addr_in;
  logic       wr_req;
  logic       rd_req;
  logic       auto_inc;
  logic [7:0] wdata;
  logic       busy;
  logic       rd_valid;
  logic [7:0] rdata;
  logic [3:0] mar;
  logic [3:0] ram_addr;
  logic       ram_cs_n;
  logic       ram_we_n;
  logic [7:0] ram_d;
  logic [7:0] ram_q;

  modport slave (
    input  mar_load, addr_in, wr_req, rd_req, auto_inc, wdata, ram_q,
    output busy, rd_valid, rdata, mar, ram_addr, ram_cs_n, ram_we_n, ram_d
  );

  modport master (
    output mar_load, addr_in, wr_req, rd_req, auto_inc, wdata, ram_q,
    input  busy, rd_valid, rdata, mar, ram_addr, ram_cs_n, ram_we_n, ram_d
  );
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl -- controller for a 16x8 memory built from two 16x4 RAM chips that
// share address, chip select and write enable. The chips return complemented
// data; the controller re-inverts it so rdata is true data.
//
// Ports:
//   clk    : system clock, all state on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ram_ctrl_if.slave -- host requests/status and RAM chip pins
//
// Write: WR_SETUP (cs) -> WR_PULSE (cs+we) -> WR_HOLD (cs) -> IDLE
// Read : RD_SETUP (cs) -> RD_CAPTURE (cs, data sampled on exit) -> IDLE
// All outputs come straight from flops; their next values are computed from
// the next state so the pins line up with the state they belong to.
module ram_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  ram_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR_SETUP   = 3'd1,
    WR_PULSE   = 3'd2,
    WR_HOLD    = 3'd3,
    RD_SETUP   = 3'd4,
    RD_CAPTURE = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] mar_q, mar_d;
  logic [7:0] ram_d_q, ram_d_d;
  logic       auto_inc_q, auto_inc_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rd_valid_q, rd_valid_d;
  logic       busy_q, busy_d;
  logic       ram_cs_n_q, ram_cs_n_d;
  logic       ram_we_n_q, ram_we_n_d;

  // State and output registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      mar_q      <= 4'h0;
      ram_d_q    <= 8'h00;
      auto_inc_q <= 1'b0;
      rdata_q    <= 8'h00;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      ram_cs_n_q <= 1'b1;
      ram_we_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      ram_d_q    <= ram_d_d;
      auto_inc_q <= auto_inc_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
      busy_q     <= busy_d;
      ram_cs_n_q <= ram_cs_n_d;
      ram_we_n_q <= ram_we_n_d;
    end
  end

  // Next-state logic; a write wins over a simultaneous read (read dropped)
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.wr_req) begin
          state_d = WR_SETUP;
        end else if (bus.rd_req) begin
          state_d = RD_SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      WR_SETUP:   state_d = WR_PULSE;
      WR_PULSE:   state_d = WR_HOLD;
      WR_HOLD:    state_d = IDLE;
      RD_SETUP:   state_d = RD_CAPTURE;
      RD_CAPTURE: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered pins and the datapath
  always_comb begin
    busy_d     = (state_d != IDLE);
    ram_cs_n_d = (state_d == IDLE);
    ram_we_n_d = (state_d != WR_PULSE);
    mar_d      = mar_q;
    ram_d_d    = ram_d_q;
    auto_inc_d = auto_inc_q;
    rdata_d    = rdata_q;
    rd_valid_d = 1'b0;

    if (state_q == IDLE) begin
      // MAR load in the accepting cycle means the access uses addr_in,
      // since ram_addr is driven from the MAR flop itself.
      if (bus.mar_load) begin
        mar_d = bus.addr_in;
      end else begin
        mar_d = mar_q;
      end
      if (bus.wr_req) begin
        ram_d_d    = bus.wdata;
        auto_inc_d = bus.auto_inc;
      end else begin
        ram_d_d    = ram_d_q;
        auto_inc_d = auto_inc_q;
      end
    end else if (state_q == WR_HOLD) begin
      // Post-increment only after the address has been held through the write
      if (auto_inc_q) begin
        mar_d = mar_q + 4'd1;
      end else begin
        mar_d = mar_q;
      end
    end else if (state_q == RD_CAPTURE) begin
      // Chips drive complemented data
      rdata_d    = ~bus.ram_q;
      rd_valid_d = 1'b1;
    end else begin
      mar_d = mar_q;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rdata    = rdata_q;
  assign bus.mar      = mar_q;
  assign bus.ram_addr = mar_q;
  assign bus.ram_cs_n = ram_cs_n_q;
  assign bus.ram_we_n = ram_we_n_q;
  assign bus.ram_d    = ram_d_q;

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  single system clock, all state on rising edge.
REQ-002 SHALL provide: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL provide: mar_load  input  1  load memory address register (MAR) from addr_in.
REQ-004 SHALL provide: addr_in  input  4  new MAR value.
REQ-005 SHALL provide: wr_req  input  1  write request, sampled only when busy=0.
REQ-006 SHALL provide: rd_req  input  1  read request, sampled only when busy=0.
REQ-007 SHALL provide: auto_inc  input  1  program-load mode, MAR post-increments after each write.
REQ-008 SHALL provide: wdata  input  8  write data, captured at request acceptance.
REQ-009 SHALL provide: busy  output  1  access in progress, requests ignored.
REQ-010 SHALL provide: rd_valid  output  1  one-cycle pulse, rdata updated.
REQ-011 SHALL provide: rdata  output  8  true (non-complemented) read data.
REQ-012 SHALL provide: mar  output  4  current MAR value.
REQ-013 SHALL provide: ram_addr  output  4  address to both 16x4 RAM chips, equals MAR.
REQ-014 SHALL provide: ram_cs_n  output  1  active-low chip select, shared by both chips.
REQ-015 SHALL provide: ram_we_n  output  1  active-low write enable, shared by both chips.
REQ-016 SHALL provide: ram_d  output  8  [7:4] high-nibble chip, [3:0] low-nibble chip.
REQ-017 SHALL provide: ram_q  input  8  RAM outputs, complemented by the chips.

Function
REQ-018 SHALL use FSM states IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_SETUP, RD_CAPTURE.
REQ-019 SHALL register every output; no combinational input-to-output path.
REQ-020 In IDLE, mar_load=1 SHALL set MAR<=addr_in at the next edge.
REQ-021 In IDLE, a request in the same cycle as mar_load SHALL access addr_in, not the old MAR.
REQ-022 Write accepted at edge T (IDLE, wr_req=1) SHALL give: WR_SETUP T+1, WR_PULSE T+2, WR_HOLD T+3, IDLE T+4.
REQ-023 ram_cs_n SHALL be 0 during WR_SETUP, WR_PULSE, and WR_HOLD.
REQ-024 ram_we_n SHALL be 0 in WR_PULSE only.
REQ-025 ram_d SHALL hold the captured wdata and ram_addr SHALL stay stable through all three write cycles.
REQ-026 Read accepted at edge T SHALL give: RD_SETUP T+1, RD_CAPTURE T+2, IDLE T+3.
REQ-027 ram_cs_n SHALL be 0 and ram_we_n SHALL be 1 during both read cycles.
REQ-028 At exit of RD_CAPTURE, rdata SHALL take ~ram_q and rd_valid SHALL be 1 for exactly cycle T+3.
REQ-029 rdata SHALL hold its value until the next read completes.
REQ-030 busy SHALL be 1 exactly while the FSM is not in IDLE: 3 cycles per write, 2 per read.
REQ-031 In IDLE, ram_cs_n SHALL be 1 and ram_we_n SHALL be 1.
REQ-032 wr_req and rd_req together SHALL start the write only; the read is dropped, not queued.
REQ-033 mar_load, wr_req, and rd_req while busy=1 SHALL be ignored.
REQ-034 If auto_inc=1 at write acceptance, MAR SHALL increment mod 16 on the WR_HOLD->IDLE edge (15 wraps to 0).
REQ-035 auto_inc SHALL have no effect on reads.

Reset
REQ-036 rst_n=0 SHALL immediately, independent of clk, force: state IDLE, MAR=0, ram_cs_n=1, ram_we_n=1, ram_d=0, rdata=0, rd_valid=0, busy=0.
REQ-037 Reset during WR_PULSE SHALL deassert ram_we_n asynchronously; the partial write is abandoned.
REQ-038 After rst_n rises, the first accepted request SHALL occur no earlier than the first rising clk edge.

Verification
REQ-039 Write test: mar_load addr_in=0x5, then wr_req wdata=0xA3 -> one WE pulse with ram_addr=5, ram_d=0xA3; busy high 3 cycles.
REQ-040 Read test: RAM model stores complemented data, read 0x5 -> rd_valid at T+3 with rdata=0xA3.
REQ-041 Auto-increment test: auto_inc=1, MAR=0xE, write 0x11 then 0x22 -> data at addr 0xE and 0xF, final MAR=0x0.
REQ-042 Simultaneous test: wr_req=rd_req=1 in IDLE -> write performed, no rd_valid; wr_req pulse while busy -> no second write.
REQ-043 Reset test: rst_n=0 mid WR_PULSE -> ram_we_n=1 and ram_cs_n=1 before the next clk edge; mar=0 and busy=0.
